sw_in_ctrl: RTL and testbench

Parametrised input-port controller for the simple switch, succeeding the single-port input FSM/watchdog pair. It accepts a framed packet on one input port, matches the header byte against N_PORTS output-port addresses, waits for the target port(s) under an integrated watchdog, and then forwards the payload with per-port write enables. Mid-packet truncation by maximum length and a drop-cause report are new in this generation. The block sits between the switch ingress and the output-port FIFOs.

---
 rtl/sw_in_ctrl.sv | 145 ++++++++++++++
 tb/tb_sw_in_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_in_ctrl.sv
// ============================================================================
// sw_in_ctrl : switch input-port controller (header match, watchdog, forward)
// Optional: define SW_IN_MCAST_EN to write payload to every matching port.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module sw_in_ctrl #(
    parameter int W_WIDTH    = 8,
    parameter int N_PORTS    = 4,
    parameter int WD_TIMEOUT = 16,
    parameter int MAX_LEN    = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sw_en,
    input  logic [N_PORTS-1:0]           port_busy,
    input  logic [N_PORTS*W_WIDTH-1:0]   port_addr,
    input  logic [W_WIDTH-1:0]           data_in,
    output logic                         ready,
    output logic [N_PORTS-1:0]           wr_en,
    output logic [W_WIDTH-1:0]           data_out,
    output logic                         drop,
    output logic [1:0]                   drop_cause
);

    localparam int WD_W  = $clog2(WD_TIMEOUT + 1);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(WD_TIMEOUT);
    localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN);

    localparam logic [1:0] CAUSE_NOMATCH = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_TRUNC   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FWD  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t               state_q;
    logic [N_PORTS-1:0]   mask_q;
    logic [N_PORTS-1:0]   mask_d;
    logic [N_PORTS-1:0]   match;
    logic [WD_W-1:0]      wd_q;
    logic [WD_W-1:0]      wd_d;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     len_d;
    logic [N_PORTS-1:0]   wr_en_q;
    logic [W_WIDTH-1:0]   data_out_q;
    logic                 drop_q;
    logic [1:0]           drop_cause_q;
    logic                 tgt_busy;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_match
        assign match[i] = (data_in == port_addr[i*W_WIDTH +: W_WIDTH]);
    end

`ifdef SW_IN_MCAST_EN
    assign mask_d = match;
`else
    // Isolate the lowest set bit so duplicate addresses resolve to the lowest port.
    assign mask_d = match & (~match + N_PORTS'(1));
`endif

    assign tgt_busy = |(port_busy & mask_q);
    assign wd_d     = (wd_q == WD_LIMIT)   ? wd_q  : wd_q  + WD_W'(1);
    assign len_d    = (len_q == LEN_LIMIT) ? len_q : len_q + LEN_W'(1);

    assign ready      = rst_n && (state_q != S_WAIT);
    assign wr_en      = wr_en_q;
    assign data_out   = data_out_q;
    assign drop       = drop_q;
    assign drop_cause = drop_cause_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            wd_q         <= '0;
            len_q        <= '0;
            wr_en_q      <= '0;
            data_out_q   <= '0;
            drop_q       <= 1'b0;
            drop_cause_q <= 2'b00;
        end else begin
            wr_en_q <= '0;
            drop_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sw_en) begin
                        if (|mask_d) begin
                            mask_q  <= mask_d;
                            wd_q    <= '0;
                            state_q <= S_WAIT;
                        end else begin
                            drop_q       <= 1'b1;
                            drop_cause_q <= CAUSE_NOMATCH;
                            state_q      <= S_DROP;
                        end
                    end
                end
                S_WAIT: begin
                    if (!sw_en) begin
                        state_q <= S_IDLE;
                    end else if (!tgt_busy) begin
                        len_q   <= '0;
                        state_q <= S_FWD;
                    end else begin
                        wd_q <= wd_d;
                        if (wd_d == WD_LIMIT) begin
                            drop_q       <= 1'b1;
                            drop_cause_q <= CAUSE_TIMEOUT;
                            state_q      <= S_DROP;
                        end
                    end
                end
                S_FWD: begin
                    if (!sw_en) begin
                        state_q <= S_IDLE;
                    end else if (len_q == LEN_LIMIT) begin
                        drop_q       <= 1'b1;
                        drop_cause_q <= CAUSE_TRUNC;
                        state_q      <= S_DROP;
                    end else begin
                        wr_en_q    <= mask_q;
                        data_out_q <= data_in;
                        len_q      <= len_d;
                    end
                end
                S_DROP: begin
                    if (!sw_en) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sw_in_ctrl.sv
// ============================================================================
// tb_sw_in_ctrl : self-checking bench for sw_in_ctrl (packet-level model)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_sw_in_ctrl;

    localparam int W   = 8;
    localparam int NP  = 4;
    localparam int WDT = 16;
    localparam int ML  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sw_en;
    logic [NP-1:0]   port_busy;
    logic [NP*W-1:0] port_addr;
    logic [W-1:0]    data_in;
    logic            ready;
    logic [NP-1:0]   wr_en;
    logic [W-1:0]    data_out;
    logic            drop;
    logic [1:0]      drop_cause;

    int checks = 0;
    int errors = 0;
    logic [1:0]   exp_cause;
    logic [W-1:0] exp_data;

    sw_in_ctrl #(
        .W_WIDTH    (W),
        .N_PORTS    (NP),
        .WD_TIMEOUT (WDT),
        .MAX_LEN    (ML)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_en      (sw_en),
        .port_busy  (port_busy),
        .port_addr  (port_addr),
        .data_in    (data_in),
        .ready      (ready),
        .wr_en      (wr_en),
        .data_out   (data_out),
        .drop       (drop),
        .drop_cause (drop_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [7:0] a3, input logic [7:0] a2,
                            input logic [7:0] a1, input logic [7:0] a0);
        port_addr = {a3, a2, a1, a0};
    endtask

    // Target set from the addressing rule: every match (multicast) or the lowest one.
    function automatic logic [NP-1:0] model_mask(input logic [W-1:0] h);
        logic [NP-1:0] m;
        m = '0;
        for (int i = 0; i < NP; i++) begin
            if (port_addr[i*W +: W] == h) begin
`ifdef SW_IN_MCAST_EN
                m[i] = 1'b1;
`else
                if (m == '0) m[i] = 1'b1;
`endif
            end
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic e_rdy,
                       input logic [NP-1:0] e_wr, input logic e_drop);
        checks++;
        assert (ready === e_rdy) else begin
            errors++;
            $error("FAIL %s ready got %0b exp %0b", tag, ready, e_rdy);
        end
        checks++;
        assert (wr_en === e_wr) else begin
            errors++;
            $error("FAIL %s wr_en got %b exp %b", tag, wr_en, e_wr);
        end
        checks++;
        assert (drop === e_drop) else begin
            errors++;
            $error("FAIL %s drop got %0b exp %0b", tag, drop, e_drop);
        end
        checks++;
        assert (drop_cause === exp_cause) else begin
            errors++;
            $error("FAIL %s drop_cause got %b exp %b", tag, drop_cause, exp_cause);
        end
        checks++;
        assert (data_out === exp_data) else begin
            errors++;
            $error("FAIL %s data_out got %h exp %h", tag, data_out, exp_data);
        end
    endtask

    // One framed packet: header, nbusy cycles with a target busy, nbytes payload.
    task automatic run_packet(input logic [W-1:0] hdr, input int nbytes,
                              input int nbusy, input bit abort);
        logic [NP-1:0] m;
        logic [NP-1:0] b;
        bit fwd, done;
        int j, cnt;
        m    = model_mask(hdr);
        fwd  = 0;
        done = 0;
        cnt  = 0;
        sw_en     = 1'b1;
        data_in   = hdr;
        port_busy = NP'($urandom);
        step();
        if (m == '0) begin
            exp_cause = 2'b01;
            chk("hdr_nomatch", 1'b1, '0, 1'b1);
        end else begin
            chk("hdr_match", 1'b0, '0, 1'b0);
            j = 0;
            while (!fwd && !done) begin
                if (abort && j == nbusy) begin
                    sw_en = 1'b0;
                    step();
                    chk("abort", 1'b1, '0, 1'b0);
                    return;
                end
                b = NP'($urandom);
                if (j < nbusy) begin
                    if ((b & m) == '0) b = b | m;
                end else begin
                    b = b & ~m;
                end
                port_busy = b;
                step();
                if ((b & m) != '0 && j + 1 == WDT) begin
                    exp_cause = 2'b10;
                    chk("timeout", 1'b1, '0, 1'b1);
                    done = 1;
                end else if ((b & m) != '0) begin
                    chk("wait_busy", 1'b0, '0, 1'b0);
                end else begin
                    chk("wait_free", 1'b1, '0, 1'b0);
                    fwd = 1;
                end
                j++;
            end
        end
        for (int k = 0; k < nbytes; k++) begin
            data_in   = W'($urandom);
            port_busy = NP'($urandom);
            step();
            if (fwd) begin
                cnt++;
                if (cnt <= ML) begin
                    exp_data = data_in;
                    chk("fwd_byte", 1'b1, m, 1'b0);
                end else begin
                    exp_cause = 2'b11;
                    chk("trunc", 1'b1, '0, 1'b1);
                    fwd = 0;
                end
            end else begin
                chk("drop_byte", 1'b1, '0, 1'b0);
            end
        end
        sw_en = 1'b0;
        step();
        chk("eop", 1'b1, '0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        sw_en     = 1'b0;
        port_busy = '0;
        data_in   = '0;
        exp_cause = 2'b00;
        exp_data  = '0;
        set_addr(8'h03, 8'h02, 8'h01, 8'h00);
        step();
        step();
        chk("reset", 1'b0, '0, 1'b0);
        rst_n = 1'b1;
        #1;
        checks++;
        assert (ready === 1'b1) else begin
            errors++;
            $error("FAIL idle_ready got %0b exp 1", ready);
        end

        run_packet(8'h02, 3, 0, 0);
        run_packet(8'h7F, 2, 0, 0);
        run_packet(8'h01, 3, 20, 0);
        run_packet(8'h01, 2, WDT - 1, 0);
        run_packet(8'h00, 6, 0, 0);
        run_packet(8'h02, 0, 0, 0);
        run_packet(8'h01, 2, 3, 1);

        set_addr(8'h05, 8'h05, 8'h01, 8'h00);
        run_packet(8'h05, 2, 0, 0);
        run_packet(8'h05, 2, 4, 0);

        // Reset while forwarding.
        set_addr(8'h03, 8'h02, 8'h01, 8'h00);
        sw_en     = 1'b1;
        data_in   = 8'h03;
        port_busy = '0;
        step();
        chk("rf_hdr", 1'b0, '0, 1'b0);
        step();
        chk("rf_free", 1'b1, '0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            data_in = W'($urandom);
            step();
            exp_data = data_in;
            chk("rf_byte", 1'b1, 4'b1000, 1'b0);
        end
        data_in = W'($urandom);
        rst_n   = 1'b0;
        step();
        exp_cause = 2'b00;
        exp_data  = '0;
        chk("rf_reset", 1'b0, '0, 1'b0);
        rst_n = 1'b1;
        sw_en = 1'b0;
        step();
        chk("rf_release", 1'b1, '0, 1'b0);
        run_packet(8'h03, 3, 0, 0);

        for (int p = 0; p < 40; p++) begin
            set_addr(8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
                     8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)));
            run_packet(8'($urandom_range(0, 7)), $urandom_range(0, 6),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(10, 20)
                                                   : $urandom_range(0, 4),
                       $urandom_range(0, 9) == 0);
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                port_busy = NP'($urandom);
                step();
                chk("gap", 1'b1, '0, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
